// File: rtl/sha256_core.sv
// -----------------------------------------------------------------------------
// sha256_core
//   Single-block SHA-256 compression engine. One round runs on each clock edge.
//   The controller loads a 512-bit block plus a 256-bit chaining value. The core
//   then runs ROUNDS rounds and one finalisation edge that adds the chaining
//   value back in. After that it pulses 'complete' for one cycle with the new
//   digest.
//
// Ports
//   clk       in   1    clock, rising edge
//   n_rst     in   1    asynchronous, active-low reset
//   start     in   1    begin compression; sampled only while idle
//   clear     in   1    synchronous abort back to idle (wins over start)
//   block_in  in   512  message block, [511:480] = W0 ... [31:0] = W15
//   h_in      in   256  chaining value, [255:224] = H0 ... [31:0] = H7
//   busy      out  1    high while a block is in progress
//   complete  out  1    one-cycle pulse, digest has just been updated
//   digest    out  256  result, [255:224] = H0' ... [31:0] = H7'
//
// Handshake: start acts as 'valid' and !busy acts as 'ready'. A start seen on an
// edge where busy is low (and clear is low) is accepted, and block_in/h_in are
// captured on that edge. A start while busy is dropped, not queued. complete
// is asserted in the idle cycle that follows a block, so a start in that cycle
// is accepted and gives back-to-back blocks.
// -----------------------------------------------------------------------------
module sha256_core #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         clear,
    input  logic [511:0] block_in,
    input  logic [255:0] h_in,
    output logic         busy,
    output logic         complete,
    output logic [255:0] digest
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [1:0]   state_q;
    logic [5:0]   t_q;
    logic [255:0] h_q;
    logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, hh_q;
    // Sliding schedule window: w_q[0] is always W[t] for the current round.
    logic [31:0]  w_q [0:15];

    logic [31:0]  t1, t2, w_next;
    logic [31:0]  big_s0, big_s1, ch, maj, sm_s0, sm_s1;

    always_comb begin
        big_s1 = ror(e_q, 6) ^ ror(e_q, 11) ^ ror(e_q, 25);
        big_s0 = ror(a_q, 2) ^ ror(a_q, 13) ^ ror(a_q, 22);
        ch     = (e_q & f_q) ^ (~e_q & g_q);
        maj    = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
        t1     = hh_q + big_s1 + ch + K[t_q] + w_q[0];
        t2     = big_s0 + maj;
        sm_s0  = ror(w_q[1], 7) ^ ror(w_q[1], 18) ^ (w_q[1] >> 3);
        sm_s1  = ror(w_q[14], 17) ^ ror(w_q[14], 19) ^ (w_q[14] >> 10);
        w_next = sm_s1 + w_q[9] + sm_s0 + w_q[0];
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            h_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            e_q      <= '0;
            f_q      <= '0;
            g_q      <= '0;
            hh_q     <= '0;
            complete <= 1'b0;
            digest   <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else if (clear) begin
            // Abort: working state is left as-is; it is reloaded on the next start.
            state_q  <= S_IDLE;
            complete <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    complete <= 1'b0;
                    if (start) begin
                        h_q   <= h_in;
                        a_q   <= h_in[255:224];
                        b_q   <= h_in[223:192];
                        c_q   <= h_in[191:160];
                        d_q   <= h_in[159:128];
                        e_q   <= h_in[127:96];
                        f_q   <= h_in[95:64];
                        g_q   <= h_in[63:32];
                        hh_q  <= h_in[31:0];
                        for (int i = 0; i < 16; i++) w_q[i] <= block_in[511 - 32*i -: 32];
                        t_q     <= '0;
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    a_q  <= t1 + t2;
                    b_q  <= a_q;
                    c_q  <= b_q;
                    d_q  <= c_q;
                    e_q  <= d_q + t1;
                    f_q  <= e_q;
                    g_q  <= f_q;
                    hh_q <= g_q;
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= w_next;
                    t_q     <= t_q + 6'd1;
                    if (t_q == LAST_ROUND) state_q <= S_FINAL;
                end
                S_FINAL: begin
                    digest <= {h_q[255:224] + a_q, h_q[223:192] + b_q,
                               h_q[191:160] + c_q, h_q[159:128] + d_q,
                               h_q[127:96]  + e_q, h_q[95:64]   + f_q,
                               h_q[63:32]   + g_q, h_q[31:0]    + hh_q};
                    complete <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    complete <= 1'b0;
                end
            endcase
        end
    end

endmodule
